// File: rtl/core2wb_pkg.sv
// Shared types and width helpers for the Ibex-to-Wishbone pipelined bridge.
package core2wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_ADDR_WIDTH      = 32;
  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 256;

  // Width needed to hold 0..max_out inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/core2wb_watchdog.sv
// Response watchdog: counts cycles while enabled and not cleared, flags the
// cycle in which the count would reach TIMEOUT_CYCLES. Never fires when 0.
module core2wb_watchdog
  import core2wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_c
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_c;
    assign unused_c = clk ^ rst_n ^ clear_i ^ enable_i;
    assign expire_c = 1'b0;
  end else begin : g_on
    localparam int unsigned    WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_d;
      end
    end

    always_comb begin
      wd_d = wd_q;
      if (clear_i) begin
        wd_d = '0;
      end else if (enable_i) begin
        wd_d = wd_q + WD_W'(1);
      end
    end

    assign expire_c = enable_i && !clear_i && (wd_q == LAST);
  end

endmodule

// File: rtl/core2wb_pipe.sv
// Ibex req/gnt/rvalid to Wishbone B4 pipelined master with up to
// MAX_OUTSTANDING in-flight transactions and a response watchdog.
module core2wb_pipe
  import core2wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    core_req,
  input  logic                                    core_we,
  input  logic [DATA_WIDTH/8-1:0]                 core_be,
  input  logic [ADDR_WIDTH-1:0]                   core_addr,
  input  logic [DATA_WIDTH-1:0]                   core_wdata,
  output logic                                    core_gnt,
  output logic                                    core_rvalid,
  output logic                                    core_err,
  output logic [DATA_WIDTH-1:0]                   core_rdata,
  output logic                                    wb_cyc,
  output logic                                    wb_stb,
  output logic                                    wb_we,
  output logic [ADDR_WIDTH-1:0]                   wb_adr,
  output logic [DATA_WIDTH/8-1:0]                 wb_sel,
  output logic [DATA_WIDTH-1:0]                   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]                   wb_dat_i,
  input  logic                                    wb_ack,
  input  logic                                    wb_err,
  input  logic                                    wb_stall,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0]   outstanding,
  output logic                                    timeout
);

  localparam int unsigned     BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned     CNT_W    = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;

  logic drain_c, room_c, issue_c, resp_c;
  logic wd_clear_c, wd_enable_c, wd_expire_c;

  // Issue/response qualification; bus inputs are ignored while draining.
  always_comb begin
    drain_c     = (state_q == ST_DRAIN);
    room_c      = (count_q < MAX_CNT) && !drain_c;
    issue_c     = core_req && room_c && !wb_stall;
    resp_c      = !drain_c && (wb_ack || wb_err) && (count_q != '0);
    wd_clear_c  = resp_c || (count_q == '0) || drain_c;
    wd_enable_c = (state_q == ST_BUSY);
  end

  core2wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (wd_clear_c),
    .enable_i (wd_enable_c),
    .expire_c (wd_expire_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, in-flight count and timeout pulse.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timeout_d = wd_expire_c;
    if (drain_c) begin
      count_d = (count_q != '0) ? count_q - CNT_W'(1) : '0;
    end else begin
      count_d = count_q + CNT_W'(issue_c) - CNT_W'(resp_c);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (issue_c) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (wd_expire_c)         state_d = ST_DRAIN;
        else if (count_d == '0)  state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (count_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; a drain flushes every in-flight transaction as an error.
  always_comb begin
    wb_stb      = core_req && room_c;
    core_gnt    = issue_c;
    wb_cyc      = !drain_c && (wb_stb || (count_q != '0));
    core_rvalid = resp_c;
    core_err    = resp_c && wb_err;
    core_rdata  = wb_dat_i;
    if (drain_c) begin
      core_rvalid = (count_q != '0);
      core_err    = (count_q != '0);
      core_rdata  = '0;
    end
  end

  assign wb_we       = core_we;
  assign wb_adr      = core_addr;
  assign wb_dat_o    = core_wdata;
  assign wb_sel      = core_we ? core_be : {BE_WIDTH{1'b1}};
  assign outstanding = count_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_core2wb_pipe.sv
// Scoreboard bench for core2wb_pipe: bus slave model, in-order response queue,
// per-cycle monitor against a transaction-level model of the bridge.
module tb_core2wb_pipe;

  localparam int MAX_OUT = 2;
  localparam int TMO     = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_rvalid, core_err;
  logic [31:0] core_rdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err, wb_stall;
  logic [1:0]  outstanding;
  logic        timeout;

  core2wb_pipe #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_err(core_err),
    .core_rdata(core_rdata),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall),
    .outstanding(outstanding), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic err; logic [31:0] data; } resp_t;
  typedef struct packed { int rdy; logic err; logic both; logic [31:0] data; } pend_t;

  resp_t sb[$];
  pend_t pend[$];

  int n_tests = 0, n_fail = 0;
  int cyc_n = 0;
  int model_cnt = 0, idle_cnt = 0, peak = 0;
  logic drain = 0, to_pending = 0, sl_resp = 0;

  // slave / test knobs
  logic mute = 0, rand_stall = 0, spur_en = 0, spur_once = 0, err_en = 0;
  logic force_err = 0, force_both = 0, fix_en = 0;
  logic [31:0] fix_data = '0;
  int dmin = 1, dmax = 1, stall_hold = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Wishbone slave: in-order responses with per-transaction latency.
  pend_t ps;
  always @(posedge clk) begin
    #1;
    cyc_n++;
    sl_resp  = 1'b0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_dat_i = $urandom;
    if (stall_hold > 0) begin
      wb_stall = 1'b1;
      stall_hold--;
    end else begin
      wb_stall = rand_stall && ($urandom % 4 == 0);
    end
    if (!mute && pend.size() != 0 && pend[0].rdy <= cyc_n) begin
      ps       = pend.pop_front();
      wb_dat_i = ps.data;
      wb_err   = ps.err;
      wb_ack   = !ps.err || ps.both;
      sl_resp  = 1'b1;
    end else if (pend.size() == 0 && (spur_once || (spur_en && $urandom % 8 == 0))) begin
      wb_ack    = 1'b1;
      wb_err    = 1'($urandom % 2);
      spur_once = 1'b0;
    end
  end

  // Monitor: compares DUT against the transaction-level model every cycle.
  logic  exp_stb, exp_rv;
  resp_t rs;
  pend_t pn;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("timeout_pulse", 64'(timeout), 64'(to_pending));
      if (to_pending) begin
        drain = 1'b1;
        sb.delete();
        pend.delete();
        for (int i = 0; i < model_cnt; i++) begin
          rs.err = 1'b1; rs.data = '0; sb.push_back(rs);
        end
      end
      to_pending = 1'b0;
      exp_stb = core_req && !drain && (model_cnt < MAX_OUT);
      chk("outstanding", 64'(outstanding), 64'(model_cnt));
      chk("wb_stb", 64'(wb_stb), 64'(exp_stb));
      chk("core_gnt", 64'(core_gnt), 64'(exp_stb && !wb_stall));
      chk("wb_cyc", 64'(wb_cyc), 64'(!drain && (exp_stb || model_cnt != 0)));
      if (core_gnt) begin
        chk("wb_adr", 64'(wb_adr), 64'(core_addr));
        chk("wb_we", 64'(wb_we), 64'(core_we));
        chk("wb_dat_o", 64'(wb_dat_o), 64'(core_wdata));
        chk("wb_sel", 64'(wb_sel), 64'(core_we ? core_be : 4'hF));
        pn.rdy  = cyc_n + $urandom_range(dmax, dmin);
        pn.err  = force_err || (err_en && ($urandom % 8 == 0));
        pn.both = force_both || ($urandom % 2 == 0);
        pn.data = fix_en ? fix_data : $urandom;
        pend.push_back(pn);
        rs.err = pn.err; rs.data = pn.data; sb.push_back(rs);
      end
      exp_rv = drain ? (model_cnt != 0) : sl_resp;
      chk("core_rvalid", 64'(core_rvalid), 64'(exp_rv));
      if (core_rvalid && exp_rv) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 64'(0), 64'(1));
        end else begin
          rs = sb.pop_front();
          chk("core_err", 64'(core_err), 64'(rs.err));
          chk("core_rdata", 64'(core_rdata), 64'(rs.data));
        end
      end
      // abort after TMO consecutive cycles with work in flight and no answer
      if (!drain && model_cnt != 0 && !exp_rv) idle_cnt++;
      else idle_cnt = 0;
      if (idle_cnt == TMO) begin to_pending = 1'b1; idle_cnt = 0; end
      if (drain) begin
        if (model_cnt == 0) drain = 1'b0;
        else model_cnt--;
      end else begin
        model_cnt = model_cnt + int'(core_gnt) - int'(exp_rv);
      end
      if (int'(outstanding) > peak) peak = int'(outstanding);
    end
  end

  task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] data);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = we; core_be = be; core_addr = addr; core_wdata = data;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = core_gnt;
    end
    if (!got) chk("gnt_wait_bound", 64'(0), 64'(1));
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    core_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int t0, t2;
  logic seen;

  initial begin
    rst_n = 1'b0; core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
    wb_ack = 0; wb_err = 0; wb_stall = 0; wb_dat_i = 0;
    #12;
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_gnt", 64'(core_gnt), 64'(0));
    chk("rst_rvalid", 64'(core_rvalid), 64'(0));
    chk("rst_cyc", 64'(wb_cyc), 64'(0));
    chk("rst_stb", 64'(wb_stb), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    @(negedge clk); #2; rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single read, ack next cycle
    dmin = 1; dmax = 1; fix_en = 1; fix_data = 32'hDEADBEEF;
    do_req(1'b0, 4'h0, 32'h100, 32'h0);
    @(posedge clk); #1; core_req = 1'b0;
    @(negedge clk);
    chk("single_rvalid", 64'(core_rvalid), 64'(1));
    chk("single_rdata", 64'(core_rdata), 64'hDEADBEEF);
    @(negedge clk);
    chk("single_cyc_low", 64'(wb_cyc), 64'(0));
    fix_en = 0;

    // three back-to-back writes, 3-cycle ack latency
    dmin = 3; dmax = 3; peak = 0;
    do_req(1'b1, 4'h3, 32'h200, 32'h11111111); t0 = cyc_n;
    do_req(1'b1, 4'h3, 32'h204, 32'h22222222);
    do_req(1'b1, 4'h3, 32'h208, 32'h33333333); t2 = cyc_n;
    idle(8);
    chk("pipe_third_gnt_delay", 64'(t2 - t0), 64'(4));
    chk("pipe_peak", 64'(peak), 64'(2));

    // stall held for four cycles
    dmin = 1; dmax = 1;
    stall_hold = 4;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_be = 4'h0; core_addr = 32'h300; core_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_gnt_low", 64'(core_gnt), 64'(0));
      chk("stall_stb_high", 64'(wb_stb), 64'(1));
    end
    @(negedge clk);
    chk("stall_gnt_release", 64'(core_gnt), 64'(1));
    idle(4);

    // ack and err together
    force_err = 1; force_both = 1;
    do_req(1'b0, 4'h0, 32'h400, 32'h0);
    force_err = 0; force_both = 0;
    idle(3);
    chk("err_count_zero", 64'(outstanding), 64'(0));

    // watchdog abort with two outstanding
    mute = 1;
    do_req(1'b0, 4'h0, 32'h500, 32'h0);
    do_req(1'b0, 4'h0, 32'h504, 32'h0);
    @(posedge clk); #1; core_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = timeout;
    end
    chk("timeout_seen", 64'(seen), 64'(1));
    repeat (4) @(negedge clk);
    mute = 0; spur_once = 1;
    repeat (4) @(negedge clk);
    chk("late_ack_ignored", 64'(outstanding), 64'(0));

    // randomized traffic
    dmin = 1; dmax = 4; rand_stall = 1; err_en = 1; spur_en = 1;
    for (int n = 0; n < 250; n++) begin
      if ($urandom % 4 == 0) idle($urandom_range(2, 1));
      do_req(1'($urandom % 2), 4'($urandom), $urandom, $urandom);
    end
    idle(12);
    rand_stall = 0; spur_en = 0; err_en = 0;
    idle(4);

    // asynchronous reset with two outstanding
    mute = 1; dmin = 1; dmax = 1;
    do_req(1'b0, 4'h0, 32'h600, 32'h0);
    do_req(1'b0, 4'h0, 32'h604, 32'h0);
    #2; core_req = 1'b0; rst_n = 1'b0;
    #1;
    chk("arst_outstanding", 64'(outstanding), 64'(0));
    chk("arst_rvalid", 64'(core_rvalid), 64'(0));
    chk("arst_cyc", 64'(wb_cyc), 64'(0));
    chk("arst_gnt", 64'(core_gnt), 64'(0));
    model_cnt = 0; idle_cnt = 0; drain = 0; to_pending = 0;
    sb.delete(); pend.delete();
    @(negedge clk); #2; rst_n = 1'b1; mute = 0;
    do_req(1'b1, 4'h5, 32'h700, 32'hCAFEF00D);
    idle(6);

    chk("sb_empty_end", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "time limit");
  end

endmodule
